btn_spi_launcher: RTL and testbench

Sits directly downstream of the push-button debouncer and upstream of the SPI master core. It converts debounced button levels into single-shot SPI transactions. A rising edge on the send button latches the switch byte and pulses the master's start. The block then waits for the master's done, captures the received byte and counts completed transactions. A second debounced button clears the captured state.

---
 rtl/btn_spi_launcher.sv | 153 +++++++++++++++
 tb/tb_btn_spi_launcher.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_spi_launcher.sv
// Turns debounced button levels into single-shot SPI transactions: a send edge
// launches one frame, the done pulse captures the reply and bumps a counter.
module btn_spi_launcher #(
    parameter int DATA_W         = 8,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_send,
    input  logic              btn_clr,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              spi_done,
    input  logic [DATA_W-1:0] spi_rx_data,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_tx_data,
    output logic [DATA_W-1:0] rx_latched,
    output logic [CNT_W-1:0]  txn_count,
    output logic              busy,
    output logic              err_timeout
);

    localparam int TO_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic            btn_send_q;
    logic            btn_clr_q;
    logic            send_edge_s;
    logic            clr_edge_s;
    logic            launch_s;
    logic            capture_s;
    logic            timeout_s;
    logic            to_inc_s;
    logic [TO_W-1:0] timeout_cnt_r;

    assign send_edge_s = btn_send & ~btn_send_q;
    assign clr_edge_s  = btn_clr & ~btn_clr_q;

    // Previous button levels; reset high so a button held through reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_send_q <= 1'b1;
            btn_clr_q  <= 1'b1;
        end else begin
            btn_send_q <= btn_send;
            btn_clr_q  <= btn_clr;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and transaction events.
    always_comb begin
        next_state_s = state_r;
        launch_s     = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        to_inc_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (send_edge_s) begin
                    launch_s     = 1'b1;
                    next_state_s = START;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                next_state_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (spi_done) begin
                    capture_s    = 1'b1;
                    next_state_s = IDLE;
                end else if (timeout_cnt_r == TO_LAST) begin
                    timeout_s    = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    to_inc_s     = 1'b1;
                    next_state_s = WAIT_DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Launch-side registers: start pulse, busy, held TX byte and the wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_start     <= 1'b0;
            busy          <= 1'b0;
            spi_tx_data   <= '0;
            timeout_cnt_r <= '0;
        end else begin
            spi_start <= (next_state_s == START);
            busy      <= (next_state_s != IDLE);
            if (launch_s) begin
                spi_tx_data   <= sw_data;
                timeout_cnt_r <= '0;
            end else if (to_inc_s) begin
                spi_tx_data   <= spi_tx_data;
                timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
            end else begin
                spi_tx_data   <= spi_tx_data;
                timeout_cnt_r <= timeout_cnt_r;
            end
        end
    end

    // Captured status; a clear edge overrides any capture or timeout in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_latched  <= '0;
            txn_count   <= '0;
            err_timeout <= 1'b0;
        end else if (clr_edge_s) begin
            rx_latched  <= '0;
            txn_count   <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (capture_s) begin
                rx_latched <= spi_rx_data;
                txn_count  <= txn_count + CNT_W'(1);
            end else begin
                rx_latched <= rx_latched;
                txn_count  <= txn_count;
            end
            if (timeout_s) begin
                err_timeout <= 1'b1;
            end else begin
                err_timeout <= err_timeout;
            end
        end
    end

endmodule

// File: tb/tb_btn_spi_launcher.sv
// Scoreboard bench: stimulus queues expected start pulses and completions,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_btn_spi_launcher;

    localparam int TO = 16;

    logic       clk;
    logic       rst;
    logic       btn_send;
    logic       btn_clr;
    logic [7:0] sw_data;
    logic       spi_done;
    logic [7:0] spi_rx_data;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic [7:0] rx_latched;
    logic [7:0] txn_count;
    logic       busy;
    logic       err_timeout;

    btn_spi_launcher #(.DATA_W(8), .CNT_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .btn_send(btn_send), .btn_clr(btn_clr),
        .sw_data(sw_data), .spi_done(spi_done), .spi_rx_data(spi_rx_data),
        .spi_start(spi_start), .spi_tx_data(spi_tx_data), .rx_latched(rx_latched),
        .txn_count(txn_count), .busy(busy), .err_timeout(err_timeout)
    );

    typedef struct {int cyc; logic [7:0] tx;} start_t;
    typedef struct {int cyc; logic [7:0] rx; logic [7:0] cnt; logic err;} comp_t;

    start_t start_q[$];
    comp_t  comp_q[$];
    int     cyc = 0;
    int     pass_cnt = 0;
    int     total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every start pulse and every busy fall must match a queued expectation.
    initial begin
        logic busy_prev;
        start_t s;
        comp_t  c;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
            end else begin
                if (spi_start === 1'b1) begin
                    chk("start_expected", 32'(start_q.size() != 0), 32'd1);
                    if (start_q.size() != 0) begin
                        s = start_q.pop_front();
                        chk("start_cycle", cyc, s.cyc);
                        chk("start_tx", spi_tx_data, s.tx);
                        chk("start_busy", busy, 1'b1);
                    end
                end
                if (busy_prev && busy === 1'b0) begin
                    chk("done_expected", 32'(comp_q.size() != 0), 32'd1);
                    if (comp_q.size() != 0) begin
                        c = comp_q.pop_front();
                        chk("done_cycle", cyc, c.cyc);
                        chk("done_rx", rx_latched, c.rx);
                        chk("done_cnt", txn_count, c.cnt);
                        chk("done_err", err_timeout, c.err);
                    end
                end
                busy_prev = (busy === 1'b1);
            end
        end
    end

    task automatic check_zero();
        chk("rst_start", spi_start, 1'b0);
        chk("rst_tx", spi_tx_data, 8'h00);
        chk("rst_rx", rx_latched, 8'h00);
        chk("rst_cnt", txn_count, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
    endtask

    task automatic rst_dut();
        rst = 1'b1;
        #1;
        check_zero();
        tick(2);
        rst = 1'b0;
        tick();
    endtask

    // Edge on btn_send; returns with the DUT in WAIT_DONE and sw_data scrambled.
    task automatic launch(input logic [7:0] d);
        sw_data  = d;
        btn_send = 1'b1;
        start_q.push_back('{cyc + 1, d});
        tick(2);
        btn_send = 1'b0;
        sw_data  = ~d;
    endtask

    task automatic finish_txn(input logic [7:0] rx, input logic [7:0] ecnt,
                              input logic [7:0] erx, input logic eerr);
        spi_rx_data = rx;
        spi_done    = 1'b1;
        comp_q.push_back('{cyc + 1, erx, ecnt, eerr});
        tick();
        spi_done    = 1'b0;
        spi_rx_data = 8'h00;
    endtask

    initial begin
        rst = 1'b1; btn_send = 1'b0; btn_clr = 1'b0; sw_data = 8'h00;
        spi_done = 1'b0; spi_rx_data = 8'h00;

        // Basic launch
        rst_dut();
        launch(8'hA5);
        chk("tx_held", spi_tx_data, 8'hA5);
        tick(2);
        finish_txn(8'h3C, 8'd1, 8'h3C, 1'b0);
        tick(2);

        // Hold and drop
        rst_dut();
        sw_data = 8'h11; btn_send = 1'b1;
        start_q.push_back('{cyc + 1, 8'h11});
        tick(4);
        finish_txn(8'h22, 8'd1, 8'h22, 1'b0);
        tick(95);
        btn_send = 1'b0;
        tick();
        launch(8'h33);
        btn_send = 1'b1; tick(); btn_send = 1'b0; tick(2);
        finish_txn(8'h44, 8'd2, 8'h44, 1'b0);
        tick(5);
        chk("drop_cnt", txn_count, 8'd2);

        // Timeout, then a good transaction keeps the sticky flag
        rst_dut();
        launch(8'h5A);
        comp_q.push_back('{cyc + TO, 8'h00, 8'd0, 1'b1});
        tick(TO + 2);
        launch(8'h6B);
        tick();
        finish_txn(8'h7C, 8'd1, 8'h7C, 1'b1);
        tick();

        // Clear collides with capture
        launch(8'h01);
        spi_rx_data = 8'h99; spi_done = 1'b1; btn_clr = 1'b1;
        comp_q.push_back('{cyc + 1, 8'h00, 8'd0, 1'b0});
        tick();
        spi_done = 1'b0; btn_clr = 1'b0;
        tick();
        // Clear mid-flight does not abort
        launch(8'h02);
        btn_clr = 1'b1; tick(); btn_clr = 1'b0; tick();
        finish_txn(8'h77, 8'd1, 8'h77, 1'b0);
        tick();
        // Clear collides with timeout
        launch(8'h03);
        comp_q.push_back('{cyc + TO, 8'h00, 8'd0, 1'b0});
        tick(TO - 1);
        btn_clr = 1'b1; tick(); btn_clr = 1'b0;
        tick(2);
        // Send and clear together in IDLE
        launch(8'h04);
        finish_txn(8'h55, 8'd1, 8'h55, 1'b0);
        tick();
        sw_data = 8'h66; btn_send = 1'b1; btn_clr = 1'b1;
        start_q.push_back('{cyc + 1, 8'h66});
        tick();
        chk("sendclr_cnt", txn_count, 8'd0);
        chk("sendclr_rx", rx_latched, 8'h00);
        tick();
        btn_send = 1'b0; btn_clr = 1'b0;
        finish_txn(8'h88, 8'd1, 8'h88, 1'b0);
        tick();

        // Counter wrap
        rst_dut();
        for (int i = 0; i < 257; i++) begin
            logic [7:0] d;
            d = 8'(i);
            launch(d);
            finish_txn(d ^ 8'h5A, 8'(i + 1), d ^ 8'h5A, 1'b0);
        end
        tick();
        chk("wrap_cnt", txn_count, 8'd1);

        // Button held through reset release
        btn_send = 1'b1;
        rst_dut();
        tick(5);
        btn_send = 1'b0;
        tick();
        // Reset during WAIT_DONE, then a stray done
        launch(8'hC3);
        finish_txn(8'hD4, 8'd1, 8'hD4, 1'b0);
        tick();
        launch(8'hE5);
        tick();
        rst_dut();
        spi_rx_data = 8'hFF; spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        tick(3);
        chk("late_done_cnt", txn_count, 8'd0);
        chk("late_done_rx", rx_latched, 8'h00);
        chk("late_done_busy", busy, 1'b0);

        chk("start_q_empty", start_q.size(), 32'd0);
        chk("comp_q_empty", comp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
